// File: rtl/ram2_ctrl.sv
// RAM2 SRAM sequencing controller: arbitrates IF fetch vs MEM data port and times EN/OE/WE strobes.
// Optional one-entry fetch buffer enabled by defining RAM2_CTRL_FETCH_CACHE_EN.
module ram2_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_PULSE  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              if_req,
  output logic [DATA_W-1:0] inst_o,
  output logic              inst_valid,
  input  logic              mem_ce,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_done,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_data_oe,
  output logic              ram_en_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int CNT_MAX = (RD_CYCLES > WR_PULSE) ? RD_CYCLES : WR_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_fetch_q, is_fetch_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              mem_done_q, mem_done_d;
  logic              data_oe_q, data_oe_d;
  logic              en_n_q, en_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              mem_wr_s, mem_rd_s;
  logic              fetch_hit_s;
  logic [DATA_W-1:0] hit_data_s;

`ifdef RAM2_CTRL_FETCH_CACHE_EN
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [DATA_W-1:0] cdata_q, cdata_d;
  logic              cvalid_q, cvalid_d;

  assign fetch_hit_s = cvalid_q && (tag_q == pc);
  assign hit_data_s  = cdata_q;
`else
  assign fetch_hit_s = 1'b0;
  assign hit_data_s  = {DATA_W{1'b0}};
`endif

  // A write request outranks a read even when both strobes are high.
  assign mem_wr_s = mem_ce & mem_we;
  assign mem_rd_s = mem_ce & mem_re & ~mem_we;

  // Next-state, strobe and result computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_fetch_d   = is_fetch_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    mem_data_d   = mem_data_q;
    mem_done_d   = 1'b0;
    data_oe_d    = data_oe_q;
    en_n_d       = en_n_q;
    oe_n_d       = oe_n_q;
    we_n_d       = we_n_q;
`ifdef RAM2_CTRL_FETCH_CACHE_EN
    tag_d        = tag_q;
    cdata_d      = cdata_q;
    cvalid_d     = cvalid_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_wr_s) begin
          state_d   = ST_WR_SETUP;
          addr_d    = mem_addr_i;
          wdata_d   = mem_data_i;
          data_oe_d = 1'b1;
          en_n_d    = 1'b0;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
`ifdef RAM2_CTRL_FETCH_CACHE_EN
          if (tag_q == mem_addr_i) begin
            cvalid_d = 1'b0;
          end else begin
            cvalid_d = cvalid_q;
          end
`endif
        end else if (mem_rd_s) begin
          state_d    = ST_RD;
          addr_d     = mem_addr_i;
          is_fetch_d = 1'b0;
          cnt_d      = {CNT_W{1'b0}};
          data_oe_d  = 1'b0;
          en_n_d     = 1'b0;
          oe_n_d     = 1'b0;
        end else if (if_req && fetch_hit_s) begin
          state_d      = ST_DONE;
          inst_d       = hit_data_s;
          inst_valid_d = 1'b1;
        end else if (if_req) begin
          state_d    = ST_RD;
          addr_d     = pc;
          is_fetch_d = 1'b1;
          cnt_d      = {CNT_W{1'b0}};
          data_oe_d  = 1'b0;
          en_n_d     = 1'b0;
          oe_n_d     = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (cnt_q == CNT_W'(RD_CYCLES - 1)) begin
          state_d = ST_DONE;
          en_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (is_fetch_q) begin
            inst_d       = ram_data_i;
            inst_valid_d = 1'b1;
`ifdef RAM2_CTRL_FETCH_CACHE_EN
            tag_d    = addr_q;
            cdata_d  = ram_data_i;
            cvalid_d = 1'b1;
`endif
          end else begin
            mem_data_d = ram_data_i;
            mem_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = {CNT_W{1'b0}};
      end
      ST_WR_PULSE: begin
        if (cnt_q == CNT_W'(WR_PULSE - 1)) begin
          state_d    = ST_WR_HOLD;
          we_n_d     = 1'b1;
          mem_done_d = 1'b1;
          mem_data_d = {DATA_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WR_HOLD: begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
        en_n_d    = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        data_oe_d = 1'b0;
        en_n_d    = 1'b1;
        oe_n_d    = 1'b1;
        we_n_d    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset also aborts an access mid-pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      is_fetch_q   <= 1'b0;
      addr_q       <= {ADDR_W{1'b0}};
      wdata_q      <= {DATA_W{1'b0}};
      inst_q       <= {DATA_W{1'b0}};
      inst_valid_q <= 1'b0;
      mem_data_q   <= {DATA_W{1'b0}};
      mem_done_q   <= 1'b0;
      data_oe_q    <= 1'b0;
      en_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
`ifdef RAM2_CTRL_FETCH_CACHE_EN
      tag_q        <= {ADDR_W{1'b0}};
      cdata_q      <= {DATA_W{1'b0}};
      cvalid_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_fetch_q   <= is_fetch_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      mem_data_q   <= mem_data_d;
      mem_done_q   <= mem_done_d;
      data_oe_q    <= data_oe_d;
      en_n_q       <= en_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
`ifdef RAM2_CTRL_FETCH_CACHE_EN
      tag_q        <= tag_d;
      cdata_q      <= cdata_d;
      cvalid_q     <= cvalid_d;
`endif
    end
  end

  assign inst_o      = inst_q;
  assign inst_valid  = inst_valid_q;
  assign mem_data_o  = mem_data_q;
  assign mem_done    = mem_done_q;
  assign ram_addr    = addr_q;
  assign ram_data_o  = wdata_q;
  assign ram_data_oe = data_oe_q;
  assign ram_en_n    = en_n_q;
  assign ram_oe_n    = oe_n_q;
  assign ram_we_n    = we_n_q;

  // Stall drops in the same cycle the completion pulse appears.
  assign stall_req = (if_req & ~inst_valid_q) |
                     (mem_ce & (mem_re | mem_we) & ~mem_done_q);

endmodule

// File: tb/tb_ram2_ctrl.sv
// Bench for ram2_ctrl: directed scenarios plus randomized requests checked each cycle
// against a transaction-timeline model and a behavioural SRAM.
module tb_ram2_ctrl;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RD = 2;
  localparam int WP = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc;
  logic          if_req;
  logic [DW-1:0] inst_o;
  logic          inst_valid;
  logic          mem_ce, mem_re, mem_we;
  logic [AW-1:0] mem_addr_i;
  logic [DW-1:0] mem_data_i;
  logic [DW-1:0] mem_data_o;
  logic          mem_done;
  logic          stall_req;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_data_i;
  logic          ram_data_oe, ram_en_n, ram_oe_n, ram_we_n;

  always #5 clk = ~clk;

  ram2_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_CYCLES(RD), .WR_PULSE(WP)) dut (
    .clk(clk), .rst(rst), .pc(pc), .if_req(if_req), .inst_o(inst_o),
    .inst_valid(inst_valid), .mem_ce(mem_ce), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .mem_done(mem_done), .stall_req(stall_req), .ram_addr(ram_addr),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i), .ram_data_oe(ram_data_oe),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  // SRAM device contents (written by DUT pins) and the model's view of memory
  logic [DW-1:0] sram    [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(negedge clk) begin
    if (ram_en_n === 1'b0 && ram_we_n === 1'b0) sram[ram_addr] = ram_data_o;
  end

  int vectors = 0;
  int miscompares = 0;
  int checks = 0;

  // Model: access kind 0 fetch, 1 mem read, 2 write, 3 buffer hit; k = cycle since sampling edge
  bit            model_ok = 1'b0;
  bit            m_busy = 1'b0;
  int            m_kind = 0;
  int            m_k = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0, e_inst = '0, e_mdata = '0;
  logic          e_en_n = 1'b1, e_oe_n = 1'b1, e_we_n = 1'b1, e_doe = 1'b0;
  logic          e_iv = 1'b0, e_md = 1'b0;
  bit            c_valid = 1'b0;
  logic [AW-1:0] c_tag = '0;
  logic [DW-1:0] c_data = '0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int last_k(input int kind);
    if (kind == 2) return 2 + WP;
    if (kind == 3) return 1;
    return RD + 1;
  endfunction

  task automatic start_access(input int kind, input logic [AW-1:0] a);
    m_busy = 1'b1;
    m_kind = kind;
    m_k    = 1;
    m_addr = a;
    e_addr = a;
  endtask

  task automatic model_step(input logic s_rst, input logic s_if, input logic s_ce,
                            input logic s_re, input logic s_we, input logic [AW-1:0] s_pc,
                            input logic [AW-1:0] s_ma, input logic [DW-1:0] s_md);
    logic [DW-1:0] d;
    if (s_rst) begin
      m_busy = 1'b0; e_addr = '0; e_wdata = '0; e_inst = '0; e_mdata = '0;
      c_valid = 1'b0; model_ok = 1'b1;
    end else if (m_busy) begin
      if (m_k == last_k(m_kind)) begin
        m_busy = 1'b0;
      end else begin
        m_k++;
        if (m_kind == 2 && m_k == 2) ref_mem[m_addr] = m_wdata;
        if (m_kind == 2 && m_k == 2 + WP) e_mdata = '0;
        if (m_kind <= 1 && m_k == RD + 1) begin
          d = ref_mem[m_addr];
          if (m_kind == 0) begin
            e_inst = d;
`ifdef RAM2_CTRL_FETCH_CACHE_EN
            c_valid = 1'b1; c_tag = m_addr; c_data = d;
`endif
          end else begin
            e_mdata = d;
          end
        end
      end
    end else if (s_ce && s_we) begin
      start_access(2, s_ma);
      m_wdata = s_md;
      e_wdata = s_md;
      if (c_valid && c_tag == s_ma) c_valid = 1'b0;
    end else if (s_ce && s_re) begin
      start_access(1, s_ma);
    end else if (s_if) begin
      if (c_valid && c_tag == s_pc) begin
        m_busy = 1'b1; m_kind = 3; m_k = 1; e_inst = c_data;
      end else begin
        start_access(0, s_pc);
      end
    end
    e_en_n = !(m_busy && ((m_kind <= 1 && m_k <= RD) || (m_kind == 2 && m_k <= 2 + WP)));
    e_oe_n = !(m_busy && m_kind <= 1 && m_k <= RD);
    e_we_n = !(m_busy && m_kind == 2 && m_k >= 2 && m_k <= 1 + WP);
    e_doe  = m_busy && m_kind == 2 && m_k <= 2 + WP;
    e_iv   = m_busy && ((m_kind == 0 && m_k == RD + 1) || (m_kind == 3 && m_k == 1));
    e_md   = m_busy && ((m_kind == 1 && m_k == RD + 1) || (m_kind == 2 && m_k == 2 + WP));
  endtask

  // One clock: check stall before the edge, advance model, compare registered outputs after it
  task automatic tick();
    logic s_rst, s_if, s_ce, s_re, s_we;
    logic [AW-1:0] s_pc, s_ma;
    logic [DW-1:0] s_md;
    #1;
    if (model_ok)
      chk1("stall_req", stall_req, (if_req & ~e_iv) | (mem_ce & (mem_re | mem_we) & ~e_md));
    s_rst = rst; s_if = if_req; s_ce = mem_ce; s_re = mem_re; s_we = mem_we;
    s_pc = pc; s_ma = mem_addr_i; s_md = mem_data_i;
    @(posedge clk);
    #1;
    vectors++;
    model_step(s_rst, s_if, s_ce, s_re, s_we, s_pc, s_ma, s_md);
    chk1("ram_en_n", ram_en_n, e_en_n);
    chk1("ram_oe_n", ram_oe_n, e_oe_n);
    chk1("ram_we_n", ram_we_n, e_we_n);
    chk1("ram_data_oe", ram_data_oe, e_doe);
    chk1("inst_valid", inst_valid, e_iv);
    chk1("mem_done", mem_done, e_md);
    chk16("ram_addr", ram_addr, e_addr);
    chk16("ram_data_o", ram_data_o, e_wdata);
    chk16("inst_o", inst_o, e_inst);
    chk16("mem_data_o", mem_data_o, e_mdata);
    chk1("we_oe_overlap", !ram_we_n && !ram_oe_n, 1'b0);
    chk1("doe_oe_overlap", ram_data_oe && !ram_oe_n, 1'b0);
    ram_data_i = (ram_en_n === 1'b0 && ram_oe_n === 1'b0) ? sram[ram_addr] : DW'($urandom);
  endtask

  task automatic set_idle();
    if_req = 1'b0; mem_ce = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
  endtask

  task automatic mem_req(input logic re, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    mem_ce = 1'b1; mem_re = re; mem_we = we; mem_addr_i = a; mem_data_i = d;
  endtask

  bit mem_act = 1'b0;
  bit f_act = 1'b0;
  int sel;

  initial begin
    for (int a = 0; a < 65536; a++) begin
      sram[a]    = 16'(a) ^ 16'hA5A5;
      ref_mem[a] = 16'(a) ^ 16'hA5A5;
    end
    rst = 1'b1; pc = '0; mem_addr_i = '0; mem_data_i = '0; ram_data_i = '0;
    set_idle();
    tick();
    tick();
    chk1("rst_en_n", ram_en_n, 1'b1);
    chk1("rst_we_n", ram_we_n, 1'b1);
    chk16("rst_inst_o", inst_o, 16'h0000);
    rst = 1'b0;
    tick();

    // Fetch pc 3
    sram[3] = 16'hE151; ref_mem[3] = 16'hE151;
    pc = 16'h0003; if_req = 1'b1;
    tick();
    chk16("f_addr", ram_addr, 16'h0003);
    chk1("f_oe1", ram_oe_n, 1'b0);
    tick();
    chk1("f_oe2", ram_oe_n, 1'b0);
    chk1("f_noval", inst_valid, 1'b0);
    tick();
    chk1("f_val", inst_valid, 1'b1);
    chk16("f_inst", inst_o, 16'hE151);
    chk1("f_stall", stall_req, 1'b0);
    if_req = 1'b0;
    tick(); tick();

    // Write 0x6911 to 0x0010
    mem_req(1'b0, 1'b1, 16'h0010, 16'h6911);
    tick();
    chk1("w_setup_we", ram_we_n, 1'b1);
    chk1("w_setup_doe", ram_data_oe, 1'b1);
    chk16("w_setup_data", ram_data_o, 16'h6911);
    tick();
    chk1("w_pulse_we", ram_we_n, 1'b0);
    chk1("w_pulse_oe", ram_oe_n, 1'b1);
    tick();
    chk1("w_hold_we", ram_we_n, 1'b1);
    chk1("w_hold_done", mem_done, 1'b1);
    chk16("w_sram", sram[16'h0010], 16'h6911);
    set_idle();
    tick();
    chk1("w_rel_doe", ram_data_oe, 1'b0);
    tick();

    // Simultaneous fetch and MEM read: MEM first
    sram[16'h0020] = 16'h1234; ref_mem[16'h0020] = 16'h1234;
    pc = 16'h0004; if_req = 1'b1;
    mem_req(1'b1, 1'b0, 16'h0020, 16'h0000);
    tick();
    chk16("a_addr", ram_addr, 16'h0020);
    tick(); tick();
    chk1("a_done", mem_done, 1'b1);
    chk16("a_data", mem_data_o, 16'h1234);
    chk1("a_stall", stall_req, 1'b1);
    mem_ce = 1'b0; mem_re = 1'b0;
    tick(); tick();
    chk16("a_faddr", ram_addr, 16'h0004);
    tick(); tick();
    chk1("a_fval", inst_valid, 1'b1);
    chk16("a_finst", inst_o, 16'hA5A1);
    if_req = 1'b0;
    tick(); tick();

    // re and we together: write only, mem_data_o cleared
    mem_req(1'b1, 1'b1, 16'h0030, 16'hBEEF);
    tick();
    chk1("rw_oe", ram_oe_n, 1'b1);
    tick(); tick();
    chk1("rw_done", mem_done, 1'b1);
    chk16("rw_data", mem_data_o, 16'h0000);
    set_idle();
    tick(); tick();

    // Reset during the write pulse
    mem_req(1'b0, 1'b1, 16'h0040, 16'h5A5A);
    tick(); tick();
    chk1("r_pulse", ram_we_n, 1'b0);
    rst = 1'b1;
    tick();
    chk1("r_we", ram_we_n, 1'b1);
    chk1("r_doe", ram_data_oe, 1'b0);
    chk1("r_en", ram_en_n, 1'b1);
    rst = 1'b0; set_idle();
    tick();
    chk1("r_nodone", mem_done, 1'b0);
    tick();

`ifdef RAM2_CTRL_FETCH_CACHE_EN
    pc = 16'h0005; if_req = 1'b1;
    tick(); tick(); tick();
    chk1("c_miss_val", inst_valid, 1'b1);
    if_req = 1'b0; tick(); tick();
    if_req = 1'b1;
    tick();
    chk1("c_hit_val", inst_valid, 1'b1);
    chk16("c_hit_inst", inst_o, 16'hA5A0);
    chk1("c_hit_en", ram_en_n, 1'b1);
    if_req = 1'b0; tick(); tick();
    mem_req(1'b0, 1'b1, 16'h0005, 16'h0F0F);
    tick(); tick(); tick();
    set_idle(); tick(); tick();
    pc = 16'h0005; if_req = 1'b1;
    tick();
    chk1("c_inv_oe", ram_oe_n, 1'b0);
    tick(); tick();
    chk16("c_inv_inst", inst_o, 16'h0F0F);
    if_req = 1'b0; tick(); tick();
`endif

    // Randomized requesters holding requests until their completion pulse
    for (int i = 0; i < 3000; i++) begin
      if (e_md) mem_act = 1'b0;
      if (e_iv) f_act = 1'b0;
      if (!mem_act && $urandom_range(0, 2) == 0) begin
        mem_act = 1'b1;
        sel = $urandom_range(0, 3);
        mem_req(sel == 0 || sel == 2, sel != 0, AW'($urandom_range(0, 31)), DW'($urandom));
      end else if (!mem_act) begin
        mem_ce = 1'b0; mem_re = 1'($urandom); mem_we = 1'($urandom);
        mem_addr_i = AW'($urandom);
      end
      if (!f_act && $urandom_range(0, 1) == 1) begin
        f_act = 1'b1; if_req = 1'b1;
        if ($urandom_range(0, 1) == 1) pc = AW'($urandom_range(0, 15));
      end else if (!f_act) begin
        if_req = 1'b0;
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    set_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
